// File: rtl/tri_band_fill_mem.sv
// Row memory with a triangle/band fill sequencer, masked external write port, read-first
// registered read (1 cycle) and registered a&b; no backpressure, the fill drops colliding writes.
module tri_band_fill_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ROWS   = 7,
  parameter int PRIO_B = 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  output logic             wr_err,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] and_out
);

  generate
    if (ROWS < 1 || ROWS > DEPTH) begin : g_bad_rows
      $error("tri_band_fill_mem: ROWS must be within 1..DEPTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_row;
  logic [WIDTH-1:0] r_a_cap;
  logic [WIDTH-1:0] r_b_cap;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_and;
  logic             r_busy;
  logic             r_done;
  logic             r_wr_err;

  logic [WIDTH-1:0] w_fill_word;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Below the diagonal from A, above from B; the diagonal bit follows PRIO_B.
  always_comb begin
    w_fill_word = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < int'(r_row))
        w_fill_word[j] = r_a_cap[j];
      else if (j > int'(r_row))
        w_fill_word[j] = r_b_cap[j];
      else
        w_fill_word[j] = (PRIO_B != 0) ? r_b_cap[j] : r_a_cap[j];
    end
  end

  assign w_wr_ok = wr_en && (int'(wr_addr) < DEPTH) && (r_state != S_FILL);
  assign w_rd_ok = int'(rd_addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_a_cap   <= '0;
      r_b_cap   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_err  <= 1'b0;
      r_rd_data <= '0;
      r_and     <= '0;
    end else begin
      r_and     <= a_word & b_word;
      r_rd_data <= w_rd_ok ? r_mem[rd_addr] : '0;
      r_wr_err  <= wr_en && !w_wr_ok;
      if (w_wr_ok)
        r_mem[wr_addr] <= (r_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_cap <= a_word;
            r_b_cap <= b_word;
            r_row   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          r_mem[r_row] <= w_fill_word;
          if (r_row == AW'(ROWS - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign wr_err  = r_wr_err;
  assign rd_data = r_rd_data;
  assign and_out = r_and;

endmodule

// File: tb/tb_tri_band_fill_mem.sv
// Directed bench: dut1 uses defaults (PRIO_B=1), dut2 uses PRIO_B=0 with DEPTH=12 for out-of-range addresses.
module tb_tri_band_fill_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_word, b_word, wr_data, wr_mask;
  logic       start, wr_en;
  logic [3:0] wr_addr, rd_addr;

  logic       busy1, done1, wr_err1, busy2, done2, wr_err2;
  logic [7:0] rd1, rd2, and1, and2;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [7:0] T1B [0:6] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
  localparam logic [7:0] T1A [0:6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
  localparam logic [7:0] T2B [0:6] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0};
  localparam logic [7:0] T2A [0:6] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  always #5 clk = ~clk;

  tri_band_fill_mem dut1 (
    .clk(clk), .rst(rst), .a_word(a_word), .b_word(b_word), .start(start),
    .busy(busy1), .done(done1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_err(wr_err1), .rd_addr(rd_addr), .rd_data(rd1), .and_out(and1)
  );

  tri_band_fill_mem #(.WIDTH(8), .DEPTH(12), .ROWS(7), .PRIO_B(0)) dut2 (
    .clk(clk), .rst(rst), .a_word(a_word), .b_word(b_word), .start(start),
    .busy(busy2), .done(done2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_err(wr_err2), .rd_addr(rd_addr), .rd_data(rd2), .and_out(and2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int addr, input logic [7:0] e1, input logic [7:0] e2, input string tag);
    rd_addr = 4'(addr);
    step();
    chk($sformatf("%s_r%0d_d1", tag, addr), {24'h0, rd1}, {24'h0, e1});
    chk($sformatf("%s_r%0d_d2", tag, addr), {24'h0, rd2}, {24'h0, e2});
  endtask

  // Runs one fill and observes 20 cycles from the start edge (E0 sample is cycle 0).
  task automatic do_fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] am,
                         input logic [7:0] bm, input int wr_at, input int st_at,
                         input int exp_err, input string tag);
    int bc1 = 0, dc1 = 0, dat = -1, bc2 = 0, dc2 = 0, ec1 = 0, ec2 = 0;
    a_word = a; b_word = b; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy1) bc1++;
      if (busy2) bc2++;
      if (done1) begin dc1++; dat = c; end
      if (done2) dc2++;
      if (wr_err1) ec1++;
      if (wr_err2) ec2++;
      if (c == 2) begin a_word = am; b_word = bm; end
      wr_en = (c == wr_at);
      start = (c == st_at);
      step();
    end
    chk({tag, "_busy1"}, bc1, 7);
    chk({tag, "_busy2"}, bc2, 7);
    chk({tag, "_done1"}, dc1, 1);
    chk({tag, "_done2"}, dc2, 1);
    chk({tag, "_done_at"}, dat, 7);
    chk({tag, "_werr1"}, ec1, exp_err);
    chk({tag, "_werr2"}, ec2, exp_err);
  endtask

  initial begin
    rst = 1'b1; a_word = 8'hFF; b_word = 8'hFF; start = 1'b0; wr_en = 1'b0;
    wr_addr = 4'd0; wr_data = 8'h00; wr_mask = 8'h00; rd_addr = 4'd0;
    step();
    step();
    chk("rst_busy", {31'h0, busy1}, 0);
    chk("rst_done", {31'h0, done1}, 0);
    chk("rst_werr", {31'h0, wr_err1}, 0);
    chk("rst_rd", {24'h0, rd1}, 0);
    chk("rst_and", {24'h0, and1}, 0);
    rst = 1'b0;
    step();
    chk("and_ff", {24'h0, and1}, 32'hFF);

    // Lower triangle: a=FF, b=00.
    do_fill(8'hFF, 8'h00, 8'hFF, 8'h00, -1, -1, 0, "f1");
    for (int r = 0; r < 16; r++)
      rd(r, (r < 7) ? T1B[r] : 8'h00, (r < 7) ? T1A[r] : 8'h00, "f1");

    // Upper band with inputs changed mid-fill to 5A.
    do_fill(8'h00, 8'hFF, 8'h5A, 8'h5A, -1, -1, 0, "f2");
    for (int r = 0; r < 8; r++)
      rd(r, (r < 7) ? T2B[r] : 8'h00, (r < 7) ? T2A[r] : 8'h00, "f2");
    chk("and_5a", {24'h0, and2}, 32'h5A);
    a_word = 8'hF0; b_word = 8'h3C;
    chk("and_hold", {24'h0, and1}, 32'h5A);
    step();
    chk("and_30", {24'h0, and1}, 32'h30);

    // Masked write issued mid-fill is dropped.
    wr_addr = 4'd3; wr_data = 8'hAA; wr_mask = 8'hF0;
    do_fill(8'hFF, 8'h00, 8'hFF, 8'h00, 1, -1, 1, "f3");
    // Same write in IDLE, read of the same row in the same cycle sees the old word.
    wr_en = 1'b1; rd_addr = 4'd3;
    step();
    wr_en = 1'b0;
    chk("wr_old1", {24'h0, rd1}, 32'h07);
    chk("wr_old2", {24'h0, rd2}, 32'h0F);
    chk("wr_ok_err", {31'h0, wr_err1}, 0);
    step();
    chk("wr_new1", {24'h0, rd1}, 32'hA7);
    chk("wr_new2", {24'h0, rd2}, 32'hAF);

    // Start pulsed again while busy is ignored.
    do_fill(8'h00, 8'hFF, 8'h00, 8'hFF, -1, 3, 0, "f4");
    rd(6, 8'hC0, 8'h80, "f4");

    // Address 14 is valid for dut1, out of range for dut2.
    wr_addr = 4'd14; wr_data = 8'h3C; wr_mask = 8'hFF; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    chk("oor_err1", {31'h0, wr_err1}, 0);
    chk("oor_err2", {31'h0, wr_err2}, 1);
    step();
    chk("oor_err2_clr", {31'h0, wr_err2}, 0);
    rd(14, 8'h3C, 8'h00, "oor");

    // Reset at fill row 4 aborts the fill and clears everything.
    a_word = 8'hFF; b_word = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    chk("ab_busy_on", {31'h0, busy1}, 1);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_busy", {31'h0, busy1}, 0);
    begin
      int dcnt = 0;
      for (int c = 0; c < 12; c++) begin
        if (done1 || done2 || busy1) dcnt++;
        step();
      end
      chk("ab_no_done", dcnt, 0);
    end
    for (int r = 0; r < 16; r++)
      rd(r, 8'h00, 8'h00, "ab");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
